// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: result source, arbiter state,
// the buffered long-latency request payload and a one-hot helper.
package wb_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam logic [RW-1:0] REG_ZERO = 5'd0;

  // Which source drives the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_LU   = 2'd2
  } wb_src_e;

  // NORMAL arbitrates by priority; DRAIN is the one-cycle forced dequeue.
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // One-hot register mask for a destination index.
  function automatic logic [XLEN-1:0] onehot_rd(input logic [RW-1:0] rd);
    return XLEN'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO of long-latency writeback requests.
// Ports: clk/reset (sync, active-high), push/din enqueue, pop dequeues head,
// full/empty status, ent_valid/ent_rd expose every slot for the pending mask.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_req_t                  din,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         ent_valid,
  output logic [DEPTH-1:0][RW-1:0] ent_rd
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  wb_req_t          mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] valid;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_comb begin
    ent_valid = valid;
    for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter driving the single register-file write port.
// Ports: clk/reset (sync, active-high); wb_* pipeline result (priority);
// lu_* long-latency result with lu_ready backpressure; wb_stall asks the
// pipeline to hold for one cycle; we3/a3/wd3 registered write port;
// pend_mask marks destinations with a buffered, uncommitted write.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lu_valid,
  input  logic [RW-1:0]   lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic            wb_stall,
  output logic            we3,
  output logic [RW-1:0]   a3,
  output logic [XLEN-1:0] wd3,
  output logic [XLEN-1:0] pend_mask
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  wb_state_e                state;
  wb_src_e                  sel;
  logic [SW-1:0]            starve_cnt;
  logic [SW-1:0]            starve_nxt;
  logic                     out_from_lu;
  logic                     pipe_req;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  wb_req_t                  fifo_head;
  wb_req_t                  fifo_din;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][RW-1:0] ent_rd;
  logic                     hazard;

  assign pipe_req   = wb_valid && (wb_rd != REG_ZERO);
  assign lu_ready   = !fifo_full;
  // x0 results are accepted but never buffered.
  assign push       = lu_valid && !fifo_full && (lu_rd != REG_ZERO);
  assign fifo_din   = '{rd: lu_rd, data: lu_data};
  assign pop        = (sel == SRC_LU);
  assign starve_nxt = starve_cnt + SW'(1);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .din       (fifo_din),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // Source selection: DRAIN ignores the pipeline; otherwise pipeline first.
  always_comb begin
    sel = SRC_NONE;
    if (state == ST_DRAIN) begin
      if (!fifo_empty) sel = SRC_LU;
    end else if (pipe_req) begin
      sel = SRC_PIPE;
    end else if (!fifo_empty) begin
      sel = SRC_LU;
    end
  end

  // Arbiter state, starvation counter and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_NORMAL;
      starve_cnt  <= '0;
      wb_stall    <= 1'b0;
      we3         <= 1'b0;
      a3          <= '0;
      wd3         <= '0;
      out_from_lu <= 1'b0;
    end else begin
      case (state)
        ST_NORMAL: begin
          wb_stall <= 1'b0;
          if (sel == SRC_PIPE && !fifo_empty) begin
            starve_cnt <= starve_nxt;
            if (starve_nxt == SW'(STARVE_MAX)) begin
              state    <= ST_DRAIN;
              wb_stall <= 1'b1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        default: begin
          state      <= ST_NORMAL;
          wb_stall   <= 1'b0;
          starve_cnt <= '0;
        end
      endcase

      case (sel)
        SRC_PIPE: begin
          we3         <= 1'b1;
          a3          <= wb_rd;
          wd3         <= wb_data;
          out_from_lu <= 1'b0;
        end
        SRC_LU: begin
          we3         <= 1'b1;
          a3          <= fifo_head.rd;
          wd3         <= fifo_head.data;
          out_from_lu <= 1'b1;
        end
        default: begin
          we3         <= 1'b0;
          out_from_lu <= 1'b0;
        end
      endcase
    end
  end

  // Pending mask covers buffered entries plus an in-flight FIFO write.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pend_mask = pend_mask | onehot_rd(ent_rd[i]);
    end
    if (we3 && out_from_lu) pend_mask = pend_mask | onehot_rd(a3);
  end

  // Decode must never issue a pipeline write to a buffered destination.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_rd[i] == wb_rd) hazard = 1'b1;
    end
  end

  a_no_wb_hazard: assert property (@(posedge clk) disable iff (reset)
    !(state == ST_NORMAL && pipe_req && hazard));

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by random traffic,
// all checked each cycle against a queue-based reference model.
module tb_wb_arbiter;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        wb_stall;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pend_mask;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .wb_stall  (wb_stall),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  // Reference model: buffered results in arrival order plus port state.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_cnt;
  bit          m_drain;
  bit          m_stall;
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          m_from_lu;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_pend();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    if (m_we && m_from_lu) m[m_a3] = 1'b1;
    return m;
  endfunction

  task automatic model_step(input bit rst, input bit wv, input logic [4:0] wr,
                            input logic [31:0] wd, input bit lv,
                            input logic [4:0] lr, input logic [31:0] ld);
    bit          ready;
    bit          did;
    bit          from_lu;
    logic [4:0]  r;
    logic [31:0] d;
    ent_t        e;
    if (rst) begin
      mq.delete();
      m_cnt = 0; m_drain = 0; m_stall = 0;
      m_we = 0; m_a3 = '0; m_wd = '0; m_from_lu = 0;
      return;
    end
    ready = (mq.size() < DEPTH);
    did = 0; from_lu = 0; r = '0; d = '0;
    if (m_drain) begin
      if (mq.size() > 0) begin
        e = mq.pop_front(); r = e.rd; d = e.data; did = 1; from_lu = 1;
      end
      m_cnt = 0;
      m_drain = 0;
    end else if (wv && wr != 5'd0) begin
      did = 1; r = wr; d = wd;
      if (mq.size() > 0) m_cnt++;
      else m_cnt = 0;
      if (m_cnt == STARVE_MAX) m_drain = 1;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front(); r = e.rd; d = e.data; did = 1; from_lu = 1;
      end
      m_cnt = 0;
    end
    m_stall = m_drain;
    if (lv && ready && lr != 5'd0) mq.push_back('{rd: lr, data: ld});
    m_we = did;
    if (did) begin
      m_a3 = r;
      m_wd = d;
    end
    m_from_lu = did && from_lu;
  endtask

  // One clock cycle: drive at the falling edge, check after the rising edge.
  task automatic cyc(input bit rst, input bit wv, input logic [4:0] wr,
                     input logic [31:0] wd, input bit lv,
                     input logic [4:0] lr, input logic [31:0] ld);
    reset = rst; wb_valid = wv; wb_rd = wr; wb_data = wd;
    lu_valid = lv; lu_rd = lr; lu_data = ld;
    #1;
    chk("lu_ready", 32'(lu_ready), 32'(mq.size() < DEPTH));
    @(posedge clk);
    model_step(rst, wv, wr, wd, lv, lr, ld);
    @(negedge clk);
    chk("we3", 32'(we3), 32'(m_we));
    chk("a3", 32'(a3), 32'(m_a3));
    chk("wd3", wd3, m_wd);
    chk("wb_stall", 32'(wb_stall), 32'(m_stall));
    chk("pend_mask", pend_mask, exp_pend());
  endtask

  task automatic idle();
    cyc(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
  endtask

  initial begin
    logic [4:0]  pw_rd;
    logic [31:0] pw_data;
    bit          pw_v;
    bit          prev_drain;
    bit          hold;
    bit          lv;
    bit          rst;
    logic [4:0]  lr;
    logic [31:0] pm;

    reset = 1; wb_valid = 0; wb_rd = '0; wb_data = '0;
    lu_valid = 0; lu_rd = '0; lu_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Reset state
    cyc(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_pend", pend_mask, 32'd0);

    // Pipeline only
    cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    chk("pipe_a3", 32'(a3), 32'd5);
    chk("pipe_wd3", wd3, 32'hDEADBEEF);
    idle();

    // x0 results are dropped from both sources
    cyc(0, 1, 5'd0, 32'h1111, 0, 5'd0, 32'h0);
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h2222);
    idle();
    chk("x0_we3", 32'(we3), 32'd0);

    // FIFO drain with idle pipeline
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h1234);
    chk("drain_pend_n1", 32'(pend_mask[7]), 32'd1);
    idle();
    chk("drain_a3_n2", 32'(a3), 32'd7);
    chk("drain_wd3_n2", wd3, 32'h1234);
    idle();
    chk("drain_pend_n3", 32'(pend_mask[7]), 32'd0);

    // Full FIFO backpressure
    cyc(0, 1, 5'd10, 32'hA0, 1, 5'd3, 32'h30);
    cyc(0, 1, 5'd11, 32'hA1, 1, 5'd4, 32'h40);
    chk("full_pend", pend_mask, 32'h18);
    chk("full_ready", 32'(lu_ready), 32'd0);
    cyc(0, 1, 5'd12, 32'hA2, 1, 5'd5, 32'h50);
    repeat (4) idle();

    // Starvation forces a one-cycle drain
    cyc(0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99);
    for (int i = 0; i < 4; i++) cyc(0, 1, 5'(20 + i), 32'(32'hB0 + i), 0, 5'd0, 32'h0);
    chk("starve_stall", 32'(wb_stall), 32'd1);
    cyc(0, 1, 5'd24, 32'hB4, 0, 5'd0, 32'h0);
    chk("starve_lu_a3", 32'(a3), 32'd9);
    cyc(0, 1, 5'd24, 32'hB4, 0, 5'd0, 32'h0);
    chk("starve_pipe_a3", 32'(a3), 32'd24);
    idle();

    // Reset mid-operation discards buffered entries
    cyc(0, 1, 5'd1, 32'hC1, 1, 5'd13, 32'hD13);
    cyc(0, 1, 5'd2, 32'hC2, 1, 5'd14, 32'hD14);
    cyc(0, 1, 5'd15, 32'hC3, 0, 5'd0, 32'h0);
    cyc(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("midrst_we3", 32'(we3), 32'd0);
    chk("midrst_pend", pend_mask, 32'd0);
    chk("midrst_stall", 32'(wb_stall), 32'd0);
    chk("midrst_ready", 32'(lu_ready), 32'd1);
    repeat (3) idle();

    // Random traffic honouring the hazard and hold contracts
    prev_drain = 0;
    pw_v = 0; pw_rd = '0; pw_data = '0;
    for (int n = 0; n < 400; n++) begin
      hold = prev_drain;
      prev_drain = m_drain;
      if (!hold) begin
        pw_v = ($urandom_range(0, 99) < 65);
        pw_data = $urandom;
        pm = exp_pend();
        pw_rd = 5'($urandom_range(0, 31));
        for (int t = 0; t < 32 && pm[pw_rd]; t++) pw_rd = 5'($urandom_range(0, 31));
        if (pm[pw_rd]) pw_v = 0;
      end
      lv = ($urandom_range(0, 99) < 50);
      lr = 5'($urandom_range(0, 31));
      if (pw_v && lr == pw_rd) lr = lr + 5'd1;
      rst = ($urandom_range(0, 99) < 2);
      cyc(rst, pw_v, pw_rd, pw_data, lv, lr, $urandom);
      if (rst) prev_drain = 0;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback stage that drives the register file's single write port (we3/a3/wd3).
- Merges two result sources: in-order pipeline writeback (priority) and a long-latency unit (mul/div, late loads) buffered in a small FIFO.
- Publishes a pending-destination mask so decode can stall on RAW/WAW against buffered results.
- Bounds starvation of the long-latency path by requesting a one-cycle pipeline stall.

Parameters:
DEPTH, 2, long-latency FIFO entries (power of two, >=2)
STARVE_MAX, 4, consecutive cycles a non-empty FIFO head may be bypassed before a stall is requested (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
wb_valid  in  1  pipeline result valid this cycle
wb_rd  in  5  pipeline destination register
wb_data  in  32  pipeline result
lu_valid  in  1  long-latency result offered
lu_rd  in  5  long-latency destination register
lu_data  in  32  long-latency result
lu_ready  out  1  FIFO can accept; = !full (combinational from state)
wb_stall  out  1  registered; upstream must hold wb_* unchanged this cycle
we3  out  1  registered regfile write enable
a3  out  5  registered regfile write address
wd3  out  32  registered regfile write data
pend_mask  out  32  bit r = 1 while a FIFO-sourced write to r is not yet committed

Behaviour:
- Reset (clk edge with reset=1): we3=0, a3=0, wd3=0, wb_stall=0, FIFO empty, starve counter=0, state=NORMAL, pend_mask=0. Takes effect mid-operation: buffered entries are discarded, not written.
- Enqueue: lu accepted when lu_valid && lu_ready.
  - If lu_rd==0, the accept completes but nothing is enqueued.
  - An entry accepted in cycle N is eligible for selection in cycle N+1 at the earliest; there is no bypass path.
- Selection each cycle (state NORMAL):
  - If wb_valid && wb_rd!=0, the pipeline write wins.
  - Otherwise, if the FIFO is non-empty, dequeue the head.
  - Otherwise, no write.
  - wb_valid with wb_rd==0 counts as no request.
- Latency: the selected write appears on we3/a3/wd3 in the next cycle, held for exactly one cycle. we3=1 never occurs with a3==0.
- Idle outputs: when no write is selected, we3=0 and a3/wd3 hold their previous values.
- Simultaneous dequeue and enqueue when full: lu_ready stays 0 while full, so there is no same-cycle refill. Depth never exceeds DEPTH.
- Starve counter:
  - Increments each NORMAL cycle the FIFO is non-empty and the pipeline wins.
  - Clears on any dequeue or when the FIFO is empty.
- State machine:
  - NORMAL -> DRAIN when the counter reaches STARVE_MAX. wb_stall=1 for the following cycle.
  - DRAIN (one cycle): wb_valid is ignored and the FIFO head is dequeued unconditionally. Counter clears; state -> NORMAL, wb_stall=0.
  - Upstream presents the same wb_* again after the stall; no pipeline result is lost.
- pend_mask: OR of one-hot(rd) over valid FIFO entries, plus the output slot while it holds a FIFO-sourced write (we3=1). Registered/derived from state only.
- Hazard contract: decode stalls any instruction whose source or destination hits pend_mask.
  - wb_rd never equals the rd of a valid FIFO entry.
  - An SVA assertion flags a violation; RTL behaviour in that case is unspecified.

Decomposition:
- Shared package: WB_SRC_E (NONE, PIPE, LU), WB_STATE_E (NORMAL, DRAIN), typedef wb_req_t {rd[4:0], data[31:0]}, localparam REG_ZERO=5'd0.
- Sub-module wb_fifo: synchronous FIFO of wb_req_t with push/pop, full/empty, and per-entry valid/rd exposure for pend_mask.

Test Plan:
- Pipeline only: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF in cycle N -> we3=1, a3=5, wd3=0xDEADBEEF in N+1; pend_mask=0 throughout.
- x0 discard: wb_rd=0 with wb_valid=1, then lu_rd=0 accepted -> we3 never 1; lu_ready stays 1; FIFO stays empty.
- FIFO drain with idle pipeline: lu_rd=7, lu_data=0x1234 accepted in N -> pend_mask[7]=1 from N+1; we3=1, a3=7 in N+2; pend_mask[7]=0 in N+3.
- Full/backpressure (DEPTH=2): accept rd=3 and rd=4 while the pipeline writes every cycle -> lu_ready=0; a third lu_valid is held off; pend_mask=0x18.
- Starvation (STARVE_MAX=4): one FIFO entry (rd=9) with wb_valid=1 every cycle -> after 4 bypassed cycles wb_stall=1 for one cycle; the FIFO write to 9 appears; the held pipeline write appears the cycle after.
- Reset mid-operation: FIFO holds 2 entries and a write is pending; assert reset one cycle -> next cycle we3=0, pend_mask=0, lu_ready=1, wb_stall=0; the discarded entries are never written.
